// File: rtl/tx_pkg.sv
// Shared types and line constants for the 8N1 serial transmitter.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int   DATA_BITS = 8;
  localparam int   CNT_BITS  = 4;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;

endpackage

// File: rtl/tx_block_if.sv
// Byte-in / serial-out handshake bundle between a byte source and tx_block.
interface tx_block_if;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       serial_out;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  serial_out,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output serial_out,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/flex_counter.sv
// Parameterized up-counter: counts 1..rollover_val and wraps to 1, with a registered
// flag that is high exactly while count_out equals rollover_val.
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic                    r_flag;
  logic [NUM_CNT_BITS-1:0] w_count_next;
  logic                    w_flag_next;

  // A clear that coincides with an enable restarts the count and counts this edge as the first.
  always_comb begin
    w_count_next = r_count;
    if (clear) begin
      w_count_next = count_enable ? NUM_CNT_BITS'(1) : '0;
    end else if (count_enable) begin
      if (r_count == rollover_val) begin
        w_count_next = NUM_CNT_BITS'(1);
      end else begin
        w_count_next = r_count + NUM_CNT_BITS'(1);
      end
    end
  end

  assign w_flag_next = (w_count_next == rollover_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_flag  <= w_flag_next;
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = r_flag;

endmodule

// File: rtl/tx_block.sv
// 8N1 serial transmitter: one byte per start/busy handshake, BIT_PERIOD clocks per bit,
// all outputs registered.
module tx_block
  import tx_pkg::*;
#(
  parameter int BIT_PERIOD = 10
) (
  input logic       clk,
  input logic       n_rst,
  tx_block_if.slave bus
);

  tx_state_t                r_state;
  logic [DATA_BITS-1:0]     r_shift;
  logic                     r_serial;
  logic                     r_busy;
  logic                     r_done;

  logic                     w_accept;
  logic                     w_timer_roll;
  logic                     w_timer_clear;
  logic                     w_timer_en;
  logic [CNT_BITS-1:0]      w_timer_cnt;
  logic                     w_bit_en;
  logic                     w_bit_wrap;
  logic [CNT_BITS-1:0]      w_bit_cnt;
  logic                     w_last_bit;
  logic                     w_state_change;
  logic                     w_unused;

  assign w_accept       = (r_state == IDLE) && bus.tx_start;
  assign w_last_bit     = (w_bit_cnt == CNT_BITS'(DATA_BITS - 1));
  assign w_state_change = (r_state != IDLE) && w_timer_roll &&
                          ((r_state != DATA) || w_last_bit);

  // The timer counts the accept edge itself, so each state lasts exactly BIT_PERIOD clocks.
  assign w_timer_clear  = w_accept || w_state_change;
  assign w_timer_en     = w_accept || (r_state != IDLE);
  assign w_bit_en       = (r_state == DATA) && w_timer_roll;

  flex_counter #(
    .NUM_CNT_BITS (CNT_BITS)
  ) u_bit_timer (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_timer_clear),
    .count_enable  (w_timer_en),
    .rollover_val  (CNT_BITS'(BIT_PERIOD)),
    .count_out     (w_timer_cnt),
    .rollover_flag (w_timer_roll)
  );

  flex_counter #(
    .NUM_CNT_BITS (CNT_BITS)
  ) u_bit_index (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (w_accept),
    .count_enable  (w_bit_en),
    .rollover_val  (CNT_BITS'(DATA_BITS)),
    .count_out     (w_bit_cnt),
    .rollover_flag (w_bit_wrap)
  );

  // Sequencing only needs the timer flag and the bit index value.
  assign w_unused = ^{w_timer_cnt, w_bit_wrap};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_serial <= IDLE_LINE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_serial <= IDLE_LINE;
          r_busy   <= 1'b0;
          if (bus.tx_start) begin
            r_shift  <= bus.tx_data;
            r_serial <= START_BIT;
            r_busy   <= 1'b1;
            r_state  <= START;
          end
        end
        START: begin
          if (w_timer_roll) begin
            r_serial <= r_shift[0];
            r_state  <= DATA;
          end
        end
        DATA: begin
          if (w_timer_roll) begin
            r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
            if (w_last_bit) begin
              r_serial <= STOP_BIT;
              r_state  <= STOP;
            end else begin
              r_serial <= r_shift[1];
            end
          end
        end
        STOP: begin
          if (w_timer_roll) begin
            r_serial <= IDLE_LINE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: begin
          r_serial <= IDLE_LINE;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.serial_out = r_serial;
  assign bus.tx_busy    = r_busy;
  assign bus.tx_done    = r_done;

endmodule

// File: tb/tb_tx_block.sv
// Randomized and directed bench for tx_block against a timing model of the 8N1 frame
// plus a bit-level decoder of the recorded line.
module tb_tx_block;

  localparam int P     = 10;
  localparam int FRAME = 10 * P;
  localparam int MAXC  = 8192;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;

  always #5 clk = ~clk;

  tx_block_if u_if ();

  tx_block #(
    .BIT_PERIOD (P)
  ) u_dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (u_if.slave)
  );

  int   n_checks   = 0;
  int   n_fail     = 0;
  int   cyc        = 0;
  int   n_done_obs = 0;
  int   n_busy_obs = 0;
  int   n_frames   = 0;
  bit   m_active   = 1'b0;
  int   m_k        = 0;
  logic [7:0] m_data = 8'h00;
  logic line_hist [MAXC];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line level d clocks after the accept edge: start, 8 data bits LSB first, stop.
  function automatic logic exp_line(input int d, input logic [7:0] data);
    int slot;
    slot = d / P;
    if (slot == 0) return 1'b0;
    else if (slot <= 8) return data[slot-1];
    else return 1'b1;
  endfunction

  task automatic tick();
    int   d;
    logic e_busy, e_done, e_ser;
    @(posedge clk);
    cyc++;
    if (n_rst && u_if.tx_start && (!m_active || (cyc - m_k) > FRAME)) begin
      m_active = 1'b1;
      m_k      = cyc;
      m_data   = u_if.tx_data;
      n_frames++;
    end
    #1;
    d      = cyc - m_k;
    e_busy = m_active && (d < FRAME);
    e_done = m_active && (d == FRAME);
    e_ser  = e_busy ? exp_line(d, m_data) : 1'b1;
    chk("serial_out", u_if.serial_out, e_ser);
    chk("tx_busy", u_if.tx_busy, e_busy);
    chk("tx_done", u_if.tx_done, e_done);
    if (u_if.tx_done === 1'b1) n_done_obs++;
    if (u_if.tx_busy === 1'b1) n_busy_obs++;
    if (e_done) $display("frame %0d data=%02h accepted at cycle %0d, done at cycle %0d",
                         n_frames, m_data, m_k, cyc);
    if (cyc < MAXC) line_hist[cyc] = u_if.serial_out;
  endtask

  // Find the first high-to-low line transition at or after 'from' and sample mid-bit.
  task automatic decode(input int from, output int s_out, output logic [7:0] b, output logic ok);
    s_out = -1;
    b     = 8'h00;
    ok    = 1'b0;
    for (int s = from; (s + FRAME < MAXC) && (s <= cyc); s++) begin
      if (line_hist[s-1] === 1'b1 && line_hist[s] === 1'b0) begin
        s_out = s;
        break;
      end
    end
    if (s_out >= 0) begin
      for (int i = 0; i < 8; i++) b[i] = line_hist[s_out + (i+1)*P + P/2];
      ok = (line_hist[s_out + P/2] === 1'b0) && (line_hist[s_out + 9*P + P/2] === 1'b1);
    end
  endtask

  task automatic send_rx(input logic [7:0] b);
    int         from, s;
    logic [7:0] got;
    logic       ok;
    from = cyc + 1;
    u_if.tx_data  = b;
    u_if.tx_start = 1'b1;
    tick();
    u_if.tx_start = 1'b0;
    u_if.tx_data  = 8'($urandom);
    repeat (FRAME + 2) tick();
    decode(from, s, got, ok);
    chk("rx_found", 32'(s >= 0), 32'd1);
    chk("rx_byte", got, b);
    chk("rx_framing", ok, 1'b1);
  endtask

  initial begin
    int         from, s1, s2, done0, busy0;
    logic [7:0] b1, b2;
    logic       ok1, ok2;

    u_if.tx_start = 1'b0;
    u_if.tx_data  = 8'h00;

    // Reset held for 3 cycles, then 20 idle cycles.
    n_rst = 1'b0;
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (20) tick();

    // Single A5 frame with an ignored FF request in the middle.
    from  = cyc + 1;
    done0 = n_done_obs;
    busy0 = n_busy_obs;
    u_if.tx_data  = 8'hA5;
    u_if.tx_start = 1'b1;
    tick();
    u_if.tx_start = 1'b0;
    repeat (40) tick();
    u_if.tx_data  = 8'hFF;
    u_if.tx_start = 1'b1;
    tick();
    u_if.tx_start = 1'b0;
    repeat (FRAME + 20) tick();
    decode(from, s1, b1, ok1);
    chk("a5_byte", b1, 8'hA5);
    chk("a5_framing", ok1, 1'b1);
    chk("a5_done_count", n_done_obs - done0, 1);
    chk("a5_busy_cycles", n_busy_obs - busy0, FRAME);

    // Back-to-back: start held high, 00 then FF.
    from = cyc + 1;
    u_if.tx_data  = 8'h00;
    u_if.tx_start = 1'b1;
    tick();
    u_if.tx_data  = 8'hFF;
    repeat (FRAME + 1) tick();
    u_if.tx_start = 1'b0;
    repeat (FRAME + 5) tick();
    decode(from, s1, b1, ok1);
    decode(s1 + FRAME, s2, b2, ok2);
    chk("b2b_first_byte", b1, 8'h00);
    chk("b2b_second_byte", b2, 8'hFF);
    chk("b2b_start_spacing", s2 - s1, FRAME + 1);
    chk("b2b_gap_high", line_hist[s1 + FRAME], 1'b1);
    chk("b2b_framing", {ok1, ok2}, 2'b11);

    // Reset during data bit 3 of 0F.
    u_if.tx_data  = 8'h0F;
    u_if.tx_start = 1'b1;
    tick();
    u_if.tx_start = 1'b0;
    repeat (4 * P + 3) tick();
    done0 = n_done_obs;
    #2 n_rst = 1'b0;
    m_active = 1'b0;
    #1;
    chk("rst_async_line", u_if.serial_out, 1'b1);
    chk("rst_async_busy", u_if.tx_busy, 1'b0);
    chk("rst_async_done", u_if.tx_done, 1'b0);
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (5) tick();
    chk("rst_no_done", n_done_obs - done0, 0);
    send_rx(8'h5A);

    // Loopback bytes.
    send_rx(8'h3C);
    send_rx(8'hC3);
    send_rx(8'h81);

    // Random requests and data churn against the timing model.
    for (int i = 0; i < 2500; i++) begin
      u_if.tx_start = ($urandom_range(0, 7) == 0);
      u_if.tx_data  = 8'($urandom);
      tick();
    end
    u_if.tx_start = 1'b0;
    repeat (FRAME + 5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
